// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// default geometry and the FIFO entry width helper.
package fetch_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ADDR_W_DEF   = 16;
  localparam logic [31:0] RESET_PC_DEF = '0;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // One skid FIFO entry carries {pc, instr}.
  function automatic int unsigned entry_width(input int unsigned addr_w);
    return XLEN + addr_w;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: memory request/response, decode handshake and
// redirect/halt control. master = fetch stage, slave = its environment.
interface instruction_fetch_if;

  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_instr;
  logic        imem_ready;

  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        id_stall;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_halt;
  logic        fetch_halted;

  modport master (
    output imem_addr, imem_rd_en, if_instr, if_pc, if_valid, fetch_halted,
    input  imem_instr, imem_ready, id_stall, redirect_valid, redirect_pc, fetch_halt
  );

  modport slave (
    input  imem_addr, imem_rd_en, if_instr, if_pc, if_valid, fetch_halted,
    output imem_instr, imem_ready, id_stall, redirect_valid, redirect_pc, fetch_halt
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous skid FIFO with flush; head is presented combinationally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointer/count bookkeeping and storage; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, BOOT/RUN/HALTED control, one memory read per
// cycle, and a skid FIFO presenting {pc, instr} to decode.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_fetch_if.master  bus
);

  localparam int unsigned ENTRY_W = entry_width(ADDR_W);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  fetch_state_e        r_state;
  logic                r_halted;
  logic [ADDR_W-1:0]   r_pc;
  logic [ENTRY_W-1:0]  r_hold;

  logic [ENTRY_W-1:0]  w_head;
  logic [ENTRY_W-1:0]  w_out;
  logic [CNT_W-1:0]    w_count;
  logic                w_empty;
  logic                w_pop;
  logic                w_room;
  logic                w_issue;
  logic                w_push;
  logic                w_unused_rpc;

  assign w_pop   = !w_empty && !bus.id_stall && !bus.redirect_valid;
  // Equivalent to (count - pop < DEPTH) without unsigned underflow.
  assign w_room  = (w_count < CNT_W'(DEPTH)) || w_pop;
  assign w_issue = (r_state == ST_RUN) && !bus.fetch_halt && !bus.redirect_valid && w_room;
  assign w_push  = w_issue && bus.imem_ready;

  assign bus.imem_rd_en = w_issue;
  assign bus.imem_addr  = 32'(r_pc);

  // Only the low ADDR_W bits of the redirect target are meaningful.
  assign w_unused_rpc = ^bus.redirect_pc;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_data  ({r_pc, bus.imem_instr}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // Control FSM; redirect forces RUN from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_BOOT;
      r_halted <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
        ST_RUN: begin
          if (bus.fetch_halt) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          r_state  <= ST_HALTED;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= ST_BOOT;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // PC: load redirect target, otherwise advance only on an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC[ADDR_W-1:0];
    end else if (bus.redirect_valid) begin
      r_pc <= bus.redirect_pc[ADDR_W-1:0];
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  // Remember the last presented entry so outputs hold while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (!w_empty) begin
      r_hold <= w_head;
    end
  end

  assign w_out            = w_empty ? r_hold : w_head;
  assign bus.if_valid     = !w_empty;
  assign bus.if_instr     = w_out[31:0];
  assign bus.if_pc        = 32'(w_out[ENTRY_W-1:32]);
  assign bus.fetch_halted = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed table, async-reset sequence,
// RESET_PC wrap instance and randomized run against a queue-based model.
module tb_instruction_fetch;

  localparam logic [31:0] TAG = 32'hA000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if u_if1 ();
  instruction_fetch_if u_if2 ();

  instruction_fetch #(.ADDR_W(16), .DEPTH(2), .RESET_PC(32'h0000_0000)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .bus (u_if1.master)
  );

  instruction_fetch #(.ADDR_W(16), .DEPTH(2), .RESET_PC(32'h0000_FFFE)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .bus (u_if2.master)
  );

  // Negedge-latched instruction memory: data = TAG | address.
  always @(negedge clk) begin
    u_if1.imem_instr <= TAG | u_if1.imem_addr;
    u_if2.imem_instr <= TAG | u_if2.imem_addr;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_halted;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rp, input logic ht,
                              input logic erd, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei, input logic eh);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rp; v.halt = ht;
    v.e_rd = erd; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei; v.e_halted = eh;
    return v;
  endfunction

  task automatic drive1(input logic st, input logic rd, input logic [31:0] rp, input logic ht, input logic rdy);
    u_if1.id_stall       = st;
    u_if1.redirect_valid = rd;
    u_if1.redirect_pc    = rp;
    u_if1.fetch_halt     = ht;
    u_if1.imem_ready     = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[21];

  // model state for the random phase
  int unsigned mq[$];
  int unsigned m_pc;
  int          m_mode;      // 0 boot, 1 run, 2 halted
  logic [31:0] m_last_pc, m_last_instr;

  initial begin
    drive1(1'b0, 1'b0, '0, 1'b0, 1'b1);
    u_if2.id_stall = 1'b0; u_if2.redirect_valid = 1'b0; u_if2.redirect_pc = '0;
    u_if2.fetch_halt = 1'b0; u_if2.imem_ready = 1'b1;

    //          stall redir rpc       halt  rd  addr      valid pc        instr           halted
    vecs[0]  = mk(0, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   32'h0,           0);
    vecs[1]  = mk(0, 0, 32'h0,   0,   1, 32'h0,   0, 32'h0,   32'h0,           0);
    vecs[2]  = mk(0, 0, 32'h0,   0,   1, 32'h1,   1, 32'h0,   TAG,             0);
    vecs[3]  = mk(0, 0, 32'h0,   0,   1, 32'h2,   1, 32'h1,   TAG | 32'h1,     0);
    vecs[4]  = mk(0, 0, 32'h0,   0,   1, 32'h3,   1, 32'h2,   TAG | 32'h2,     0);
    vecs[5]  = mk(1, 0, 32'h0,   0,   1, 32'h4,   1, 32'h3,   TAG | 32'h3,     0);
    vecs[6]  = mk(1, 0, 32'h0,   0,   0, 32'h5,   1, 32'h3,   TAG | 32'h3,     0);
    vecs[7]  = mk(1, 0, 32'h0,   0,   0, 32'h5,   1, 32'h3,   TAG | 32'h3,     0);
    vecs[8]  = mk(1, 0, 32'h0,   0,   0, 32'h5,   1, 32'h3,   TAG | 32'h3,     0);
    vecs[9]  = mk(0, 0, 32'h0,   0,   1, 32'h5,   1, 32'h3,   TAG | 32'h3,     0);
    vecs[10] = mk(0, 0, 32'h0,   0,   1, 32'h6,   1, 32'h4,   TAG | 32'h4,     0);
    vecs[11] = mk(0, 0, 32'h0,   0,   1, 32'h7,   1, 32'h5,   TAG | 32'h5,     0);
    vecs[12] = mk(1, 1, 32'h100, 0,   0, 32'h8,   1, 32'h6,   TAG | 32'h6,     0);
    vecs[13] = mk(0, 0, 32'h0,   0,   1, 32'h100, 0, 32'h6,   TAG | 32'h6,     0);
    vecs[14] = mk(0, 0, 32'h0,   0,   1, 32'h101, 1, 32'h100, TAG | 32'h100,   0);
    vecs[15] = mk(0, 0, 32'h0,   1,   0, 32'h102, 1, 32'h101, TAG | 32'h101,   0);
    vecs[16] = mk(0, 0, 32'h0,   0,   0, 32'h102, 0, 32'h101, TAG | 32'h101,   1);
    vecs[17] = mk(0, 0, 32'h0,   0,   0, 32'h102, 0, 32'h101, TAG | 32'h101,   1);
    vecs[18] = mk(0, 1, 32'h20,  0,   0, 32'h102, 0, 32'h101, TAG | 32'h101,   1);
    vecs[19] = mk(0, 0, 32'h0,   0,   1, 32'h20,  0, 32'h101, TAG | 32'h101,   0);
    vecs[20] = mk(0, 0, 32'h0,   0,   1, 32'h21,  1, 32'h20,  TAG | 32'h20,    0);

    // Release reset between edges; vector 0 is the BOOT cycle.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive1(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].halt, 1'b1);
      #2;
      chk($sformatf("v%0d rd_en", i),   32'(u_if1.imem_rd_en),   32'(vecs[i].e_rd));
      chk($sformatf("v%0d addr", i),    u_if1.imem_addr,         vecs[i].e_addr);
      chk($sformatf("v%0d valid", i),   32'(u_if1.if_valid),     32'(vecs[i].e_valid));
      chk($sformatf("v%0d if_pc", i),   u_if1.if_pc,             vecs[i].e_pc);
      chk($sformatf("v%0d if_instr", i), u_if1.if_instr,         vecs[i].e_instr);
      chk($sformatf("v%0d halted", i),  32'(u_if1.fetch_halted), 32'(vecs[i].e_halted));
      // RESET_PC=0xFFFE instance: wrap through 0xFFFF -> 0x0000
      if (i == 1) begin
        chk("wrap rd_en c2", 32'(u_if2.imem_rd_en), 32'h1);
        chk("wrap addr c2",  u_if2.imem_addr, 32'h0000_FFFE);
      end
      if (i == 2) begin
        chk("wrap addr c3",  u_if2.imem_addr, 32'h0000_FFFF);
        chk("wrap pc c3",    u_if2.if_pc,     32'h0000_FFFE);
      end
      if (i == 3) begin
        chk("wrap addr c4",  u_if2.imem_addr, 32'h0);
        chk("wrap pc c4",    u_if2.if_pc,     32'h0000_FFFF);
      end
      if (i == 4) begin
        chk("wrap pc c5",    u_if2.if_pc,     32'h0);
        chk("wrap instr c5", u_if2.if_instr,  TAG);
      end
      next_cycle();
    end

    // Asynchronous reset mid-stream, between clock edges.
    drive1(1'b0, 1'b0, '0, 1'b0, 1'b1);
    next_cycle();
    #2;
    chk("pre-reset valid", 32'(u_if1.if_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async rd_en",  32'(u_if1.imem_rd_en), 32'h0);
    chk("async valid",  32'(u_if1.if_valid),   32'h0);
    chk("async if_pc",  u_if1.if_pc,           32'h0);
    chk("async instr",  u_if1.if_instr,        32'h0);
    chk("async addr",   u_if1.imem_addr,       32'h0);
    chk("async halted", 32'(u_if1.fetch_halted), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    #2;
    chk("restart boot rd_en", 32'(u_if1.imem_rd_en), 32'h0);
    next_cycle();
    #2;
    chk("restart rd_en", 32'(u_if1.imem_rd_en), 32'h1);
    chk("restart addr",  u_if1.imem_addr,       32'h0);
    next_cycle();
    #2;
    chk("restart valid", 32'(u_if1.if_valid), 32'h1);
    chk("restart pc",    u_if1.if_pc,          32'h0);

    // Randomized run against a queue model, from a fresh reset.
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    mq.delete();
    m_pc = 0; m_mode = 0; m_last_pc = '0; m_last_instr = '0;
    for (int c = 0; c < 400; c++) begin
      logic st, rd, ht, rdy, m_valid, m_pop, m_issue;
      logic [31:0] rp;
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 5);
      ht  = ($urandom_range(0, 99) < 4);
      rdy = ($urandom_range(0, 99) < 80);
      rp  = $urandom;
      drive1(st, rd, rp, ht, rdy);
      #2;
      m_valid = (mq.size() != 0);
      if (m_valid) begin
        m_last_pc    = mq[0];
        m_last_instr = TAG | mq[0];
      end
      m_pop   = m_valid && !st && !rd;
      m_issue = (m_mode == 1) && !ht && !rd && ((int'(mq.size()) - int'(m_pop)) < 2);
      chk("rnd rd_en",  32'(u_if1.imem_rd_en),   32'(m_issue));
      chk("rnd addr",   u_if1.imem_addr,         m_pc);
      chk("rnd valid",  32'(u_if1.if_valid),     32'(m_valid));
      chk("rnd if_pc",  u_if1.if_pc,             m_last_pc);
      chk("rnd instr",  u_if1.if_instr,          m_last_instr);
      chk("rnd halted", 32'(u_if1.fetch_halted), 32'(m_mode == 2));
      if (rd) begin
        mq.delete();
        m_pc   = rp & 32'h0000_FFFF;
        m_mode = 1;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_issue && rdy) begin
          mq.push_back(m_pc);
          m_pc = (m_pc + 1) & 32'h0000_FFFF;
        end
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && ht) m_mode = 2;
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
